// File: rtl/leaf_out_stream_arbiter_if.sv
// rtl/leaf_out_stream_arbiter_if.sv - source streams and merged leaf-interface port
interface leaf_out_stream_arbiter_if #(
    parameter int NUM_SRC      = 4,
    parameter int PAYLOAD_BITS = 32
);
    logic [NUM_SRC*PAYLOAD_BITS-1:0] src_tdata;
    logic [NUM_SRC-1:0]              src_tvalid;
    logic [NUM_SRC-1:0]              src_tready;
    logic [PAYLOAD_BITS-1:0]         din_leaf_user2interface;
    logic                            vld_user2interface;
    logic                            ack_interface2user;

    // master: the arbiter side; slave: the kernel streams plus the leaf interface
    modport master (
        input  src_tdata, src_tvalid, ack_interface2user,
        output src_tready, din_leaf_user2interface, vld_user2interface
    );
    modport slave (
        output src_tdata, src_tvalid, ack_interface2user,
        input  src_tready, din_leaf_user2interface, vld_user2interface
    );
endinterface

// File: rtl/leaf_out_stream_arbiter.sv
// rtl/leaf_out_stream_arbiter.sv - burst-locked round-robin merge of user output streams onto one leaf port
module leaf_out_stream_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int SRC_BITS     = 2,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 16
) (
    input  logic                         clk,
    input  logic                         ap_rst_n,
    leaf_out_stream_arbiter_if.master    bus,
    output logic [SRC_BITS-1:0]          dout_src,
    output logic                         grant_vld,
    output logic [7:0]                   beat_cnt
);
    typedef enum logic {ARB, BURST} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t                  state;
    logic [SRC_BITS-1:0]     grant;
    logic [SRC_BITS-1:0]     last_grant;
    logic [SRC_BITS-1:0]     pick;
    logic                    found;
    logic                    load_ok;
    logic                    sel_valid;
    logic                    xfer;
    logic [PAYLOAD_BITS-1:0] sel_data;

    assign load_ok = ~bus.vld_user2interface | bus.ack_interface2user;
    assign xfer    = grant_vld & load_ok & sel_valid;

    always_comb begin
        sel_valid      = 1'b0;
        sel_data       = '0;
        bus.src_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == SRC_BITS'(i)) begin
                sel_valid         = bus.src_tvalid[i];
                sel_data          = bus.src_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                bus.src_tready[i] = grant_vld & load_ok;
            end
        end
    end

    // First valid source scanning upward from the one after last_grant
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && bus.src_tvalid[i] && ((int'(last_grant) + k) % NUM_SRC) == i) begin
                    found = 1'b1;
                    pick  = SRC_BITS'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state                       <= ARB;
            grant                       <= '0;
            last_grant                  <= SRC_BITS'(NUM_SRC - 1);
            grant_vld                   <= 1'b0;
            beat_cnt                    <= 8'd0;
            bus.vld_user2interface      <= 1'b0;
            bus.din_leaf_user2interface <= '0;
            dout_src                    <= '0;
        end else begin
            if (xfer) begin
                bus.vld_user2interface      <= 1'b1;
                bus.din_leaf_user2interface <= sel_data;
                dout_src                    <= grant;
            end else if (bus.ack_interface2user) begin
                bus.vld_user2interface <= 1'b0;
            end

            case (state)
                ARB: begin
                    if (found) begin
                        grant     <= pick;
                        beat_cnt  <= 8'd0;
                        grant_vld <= 1'b1;
                        state     <= BURST;
                    end
                end
                BURST: begin
                    // Under backpressure the grant is frozen; an idle source or a full burst releases it
                    if (load_ok) begin
                        if (!sel_valid || beat_cnt == LAST_BEAT) begin
                            last_grant <= grant;
                            grant_vld  <= 1'b0;
                            beat_cnt   <= 8'd0;
                            state      <= ARB;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_leaf_out_stream_arbiter.sv
// tb/tb_leaf_out_stream_arbiter.sv - scoreboard bench for leaf_out_stream_arbiter
module tb_leaf_out_stream_arbiter;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    leaf_out_stream_arbiter_if #(.NUM_SRC(NS), .PAYLOAD_BITS(32)) bus ();
    leaf_out_stream_arbiter_if #(.NUM_SRC(NS), .PAYLOAD_BITS(32)) bus1 ();

    logic [1:0] dout_src, dout_src1;
    logic       grant_vld, grant_vld1;
    logic [7:0] beat_cnt, beat_cnt1;

    leaf_out_stream_arbiter #(.NUM_SRC(NS), .SRC_BITS(2), .PAYLOAD_BITS(32), .BURST_LEN(4)) dut (
        .clk(clk), .ap_rst_n(rst_n), .bus(bus),
        .dout_src(dout_src), .grant_vld(grant_vld), .beat_cnt(beat_cnt)
    );
    leaf_out_stream_arbiter #(.NUM_SRC(NS), .SRC_BITS(2), .PAYLOAD_BITS(32), .BURST_LEN(1)) dut1 (
        .clk(clk), .ap_rst_n(rst_n), .bus(bus1),
        .dout_src(dout_src1), .grant_vld(grant_vld1), .beat_cnt(beat_cnt1)
    );

    logic [31:0]   sq [NS][$];
    logic [63:0]   exp_q [$];
    int            xfer_src [$];
    int            xfer_bc [$];
    int            xfer_cyc [$];
    int            out_n, cyc, errors, checks;
    logic [NS-1:0] px;
    logic          ack_nxt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            bus.src_tvalid[i]          = sq[i].size() > 0;
            bus.src_tdata[i*32 +: 32]  = sq[i].size() > 0 ? sq[i][0] : 32'h0;
        end
        bus.ack_interface2user = ack_nxt;
    endtask

    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) if (px[i]) void'(sq[i].pop_front());
        px = '0;
        drive();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (bus.src_tvalid[i] && bus.src_tready[i]) begin
                px[i] = 1'b1;
                exp_q.push_back({30'd0, 2'(i), sq[i][0]});
                xfer_src.push_back(i);
                xfer_bc.push_back(int'(beat_cnt));
                xfer_cyc.push_back(cyc);
            end
        end
        if (bus.vld_user2interface && bus.ack_interface2user) begin
            if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
            else begin
                e = exp_q.pop_front();
                chk("sb_beat", {30'd0, dout_src, bus.din_leaf_user2interface}, e);
            end
            out_n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NS; i++) sq[i].delete();
        exp_q.delete();
        xfer_src.delete();
        xfer_bc.delete();
        xfer_cyc.delete();
        out_n   = 0;
        px      = '0;
        ack_nxt = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_out(input int n);
        int c = 0;
        while (out_n < n && c < 300) begin tick(); c++; end
        chk("wait_out", 64'(out_n), 64'(n));
    endtask

    task automatic wait_xfer(input int n);
        int c = 0;
        while (xfer_src.size() < n && c < 300) begin tick(); c++; end
        chk("wait_xfer", 64'(xfer_src.size()), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0; cyc = 0; out_n = 0; px = '0; ack_nxt = 1'b1;
        rst_n = 1'b0;
        drive();
        bus1.src_tvalid         = 4'b1001;
        bus1.src_tdata          = {32'hD3, 32'h0, 32'h0, 32'hD0};
        bus1.ack_interface2user = 1'b1;

        @(negedge clk);
        chk("rst_vld", bus.vld_user2interface, 0);
        chk("rst_data", bus.din_leaf_user2interface, 0);
        chk("rst_src", dout_src, 0);
        chk("rst_tready", bus.src_tready, 0);
        chk("rst_grant", grant_vld, 0);
        chk("rst_bcnt", beat_cnt, 0);

        // BURST_LEN=1 instance: sources 0 and 3 alternate with a bubble between beats
        do_reset();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            chk("b1_vld", bus1.vld_user2interface, (k >= 2 && k % 2 == 0));
            if (k >= 2 && k % 2 == 0) begin
                chk("b1_src", dout_src1, (k % 4 == 2) ? 0 : 3);
                chk("b1_data", bus1.din_leaf_user2interface, (k % 4 == 2) ? 32'hD0 : 32'hD3);
            end
        end

        // Single source, three beats, then release and rotation past source 1
        do_reset();
        for (int j = 0; j < 3; j++) sq[1].push_back(32'hA0 + 32'(j));
        drive();
        tick();
        chk("t1_grant", grant_vld, 1);
        chk("t1_tready", bus.src_tready, 4'b0010);
        chk("t1_bcnt", beat_cnt, 0);
        chk("t1_vld0", bus.vld_user2interface, 0);
        tick(); tick(); tick();
        chk("t1_gap_hold", grant_vld, 1);
        chk("t1_out_n", 64'(out_n), 3);
        tick();
        chk("t1_release", grant_vld, 0);
        chk("t1_vld_drop", bus.vld_user2interface, 0);
        chk("t1_consec", 64'(xfer_cyc[2] - xfer_cyc[0]), 2);
        sq[0].push_back(32'hB0);
        sq[2].push_back(32'hC0);
        drive();
        tick();
        chk("t1_rr_next", bus.src_tready, 4'b0100);
        wait_out(5);

        // All sources valid: bursts of 4 in order 0,1,2,3,0 with one bubble each
        do_reset();
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < 8; j++) sq[i].push_back(32'(i * 256 + j));
        drive();
        wait_out(32);
        for (int n = 0; n < 20; n++) begin
            chk("t2_order", 64'(xfer_src[n]), 64'((n / 4) % 4));
            chk("t2_bcnt", 64'(xfer_bc[n]), 64'(n % 4));
        end
        chk("t2_span", 64'(xfer_cyc[19] - xfer_cyc[0]), 23);
        chk("t2_bubble", 64'(xfer_cyc[4] - xfer_cyc[3]), 2);

        // Backpressure mid-burst from source 2
        do_reset();
        for (int j = 0; j < 8; j++) sq[2].push_back(32'hD0 + 32'(j));
        drive();
        wait_xfer(2);
        ack_nxt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_vld", bus.vld_user2interface, 1);
            chk("t3_data", bus.din_leaf_user2interface, 32'hD1);
            chk("t3_src", dout_src, 2);
            chk("t3_tready", bus.src_tready, 0);
            chk("t3_bcnt", beat_cnt, 2);
        end
        ack_nxt = 1'b1;
        wait_out(8);
        chk("t3_sb_empty", 64'(exp_q.size()), 0);
        chk("t3_xfers", 64'(xfer_src.size()), 8);

        // Asynchronous reset with a beat held in the output register
        do_reset();
        for (int j = 0; j < 8; j++) sq[2].push_back(32'hF0 + 32'(j));
        drive();
        wait_xfer(2);
        ack_nxt = 1'b0;
        tick();
        chk("t5_pre_vld", bus.vld_user2interface, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_vld", bus.vld_user2interface, 0);
        chk("t5_tready", bus.src_tready, 0);
        chk("t5_grant", grant_vld, 0);
        chk("t5_bcnt", beat_cnt, 0);
        chk("t5_src", dout_src, 0);
        do_reset();
        sq[0].push_back(32'hE0);
        sq[2].push_back(32'hE2);
        drive();
        tick();
        chk("t5_first", bus.src_tready, 4'b0001);
        wait_out(2);
        chk("t5_seq0", 64'(xfer_src[0]), 0);
        chk("t5_seq1", 64'(xfer_src[1]), 2);

        // Source 3 goes idle after 2 beats while source 0 waits
        do_reset();
        sq[3].push_back(32'h30);
        sq[3].push_back(32'h31);
        drive();
        tick();
        chk("t6_grant3", bus.src_tready, 4'b1000);
        sq[0].push_back(32'h40);
        sq[0].push_back(32'h41);
        tick();
        chk("t6_hold3", bus.src_tready, 4'b1000);
        tick();
        chk("t6_gap", grant_vld, 1);
        chk("t6_gap_tvalid", bus.src_tvalid, 4'b0001);
        tick();
        chk("t6_release", grant_vld, 0);
        tick();
        chk("t6_next", bus.src_tready, 4'b0001);
        wait_out(4);
        chk("t6_seq", 64'(xfer_src[2]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/leaf_out_stream_arbiter.md
Name: leaf_out_stream_arbiter

Overview:
- Round-robin arbiter that shares one leaf-interface output port (32-bit payload, vld/ack handshake) between NUM_SRC user-kernel output streams (TDATA/TVALID/TREADY).
- Sits in a page wrapper between the HLS user kernel's Output_n streams and the single din_leaf_user2interface port.
- Grants are burst-locked: one source keeps the port for up to BURST_LEN beats, then arbitration rotates.
- A registered output stage gives the leaf interface a timing-clean boundary.

Parameters:
- NUM_SRC, 4, number of user output streams (2..16).
- SRC_BITS, 2, width of the source index; must be at least clog2(NUM_SRC).
- PAYLOAD_BITS, 32, data width per beat.
- BURST_LEN, 16, maximum beats per grant (1..256).

Ports:
- clk  in  1  single clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- src_tdata  in  NUM_SRC*PAYLOAD_BITS  source data; source i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- src_tvalid  in  NUM_SRC  per-source valid.
- src_tready  out  NUM_SRC  per-source ready.
- din_leaf_user2interface  out  PAYLOAD_BITS  merged data to the leaf interface.
- vld_user2interface  out  1  merged valid.
- ack_interface2user  in  1  leaf-interface ready.
- dout_src  out  SRC_BITS  index of the source whose beat is in the output register.
- grant_vld  out  1  a burst grant is active.
- beat_cnt  out  8  beats accepted in the current burst.

Behaviour:
- Reset values (asynchronous, while ap_rst_n=0):
  - All outputs 0: vld_user2interface, din_leaf_user2interface, dout_src, src_tready, grant_vld, beat_cnt.
  - Internal grant index 0.
  - last_grant = NUM_SRC-1, so source 0 has first priority after reset.
- Output register:
  - Holds one beat.
  - A beat leaves the register when vld_user2interface=1 and ack_interface2user=1.
  - load_ok = ~vld_user2interface | ack_interface2user.
- src_tready (combinational):
  - src_tready[g] = grant_vld & load_ok for the granted source g.
  - All other src_tready bits are 0.
- Transfer on source g: src_tvalid[g] & src_tready[g].
  - The next cycle the register holds that data, with vld=1 and dout_src=g.
  - Latency from source to output is 1 cycle.
  - Sustained throughput is 1 beat/cycle while ack_interface2user=1.
- If the register empties with no new load, vld_user2interface drops to 0 and data holds its last value.
- FSM, ARB state (grant_vld=0):
  - If any src_tvalid is set, pick the first asserted source scanning last_grant+1, last_grant+2, ... modulo NUM_SRC.
  - Set the grant to that source, beat_cnt=0, go to BURST.
  - If no src_tvalid is set, stay in ARB.
  - Each new grant costs exactly one bubble cycle.
- FSM, BURST state (grant_vld=1):
  - Each transfer increments beat_cnt.
  - Transfer with beat_cnt==BURST_LEN-1: release.
  - src_tvalid[g]=0 in a cycle (no transfer): release; an idle source loses the port.
  - load_ok=0 (backpressure): hold the grant, no beat counted, never release.
  - Release means: last_grant=g, grant_vld=0, beat_cnt=0, go to ARB.
- BURST_LEN=1: release after every beat, giving strict per-beat round-robin with a bubble between beats.
- src_tready never asserts in ARB, so no data is accepted in an arbitration cycle.
- Simultaneous ack with load: the register is replaced the same cycle; no beat is lost or duplicated.
- Data/valid stability: once vld_user2interface=1, data and dout_src hold until ack.
- Reset mid-burst: any beat held in the output register is discarded; vld drops immediately (async); the FSM returns to ARB with source 0 first.
- src_tvalid bits for indices >= NUM_SRC do not exist; SRC_BITS beyond clog2(NUM_SRC) are tied 0.

Test Plan:
- Reset then source 1 only, 3 beats 0xA0..0xA2 with ack=1:
  - Cycle 1: ARB grants source 1.
  - Output beats 0xA0,0xA1,0xA2 on consecutive cycles with dout_src=1.
  - Release when tvalid drops; last_grant=1.
- All 4 sources always valid, BURST_LEN=4, ack=1:
  - Grant order 0,1,2,3,0.
  - Exactly 4 beats per grant, one bubble between bursts.
  - beat_cnt runs 0..3.
- Backpressure: ack=0 for 5 cycles mid-burst from source 2:
  - vld stays 1 and data/dout_src stay stable.
  - src_tready[2]=0 and beat_cnt frozen.
  - Resuming ack gives no lost or duplicated beats.
- BURST_LEN=1, sources 0 and 3 valid:
  - Output alternates 0,3,0,3 with dout_src matching.
  - vld high every other cycle.
- ap_rst_n pulsed low mid-burst of source 2 with a beat in the register:
  - vld, src_tready and grant_vld go to 0 immediately.
  - After release, sources 0 and 2 both valid → source 0 is granted first.
- Source 3 deasserts tvalid after 2 of 16 beats while source 0 waits:
  - Grant releases after the gap cycle.
  - Source 0 is granted next.
